// File: rtl/puf_rng_pkg.sv
// Shared types and default parameters for the PUF RNG nibble collector.
package puf_rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_WORD_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_REP_LIMIT   = 8;

endpackage

// File: rtl/puf_rng_rep_check.sv
// Repetition-count health test over the accepted nibble stream.
// fail_o is combinational so the collector can discard in the same cycle.
module puf_rng_rep_check
    import puf_rng_pkg::*;
#(
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       valid_i,
    input  logic [3:0] nib_i,
    output logic       fail_o
);

    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] LIMIT_C = RW'(REP_LIMIT);

    logic [3:0]    prev_q;
    logic [RW-1:0] cnt_q;
    logic [RW-1:0] cnt_d;

    // A zero count marks "no previous nibble", so the first one always starts a run of 1.
    always_comb begin
        cnt_d = RW'(1);
        if ((cnt_q != '0) && (nib_i == prev_q)) begin
            cnt_d = cnt_q + RW'(1);
        end
    end

    assign fail_o = valid_i & (cnt_d == LIMIT_C);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else if (valid_i) begin
            prev_q <= nib_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/puf_rng_collector.sv
// Requests nibbles from the PUF core, packs them MSB-first into words,
// applies health/timeout checks and hands words downstream.
module puf_rng_collector
    import puf_rng_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int REP_LIMIT   = DEF_REP_LIMIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              rng_mode_i,
    input  logic [3:0]        rng4bit_i,
    input  logic              rng4bit_done_i,
    output logic              es_rng_req_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              timeout_err_o,
    output logic              rep_err_o,
    input  logic              err_clr_i,
    output state_t            dbg_state_o
);

    localparam int NIBS = WORD_W / 4;
    localparam int NW   = $clog2(NIBS + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC);
    localparam logic [NW-1:0] NIBS_C = NW'(NIBS);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

    state_t            state_q;
    logic [WORD_W-1:0] word_q, word_d;
    logic [NW-1:0]     nib_cnt_q, nib_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              req_q, valid_q, terr_q, rerr_q;
    logic              go, accept, hs, start_req, to_fire, rep_fail;

    // Handshake: word_o is held while word_valid_o=1; a transfer happens on
    // any cycle with word_valid_o & word_ready_i, and valid drops the next cycle.
    assign go        = enable_i & rng_mode_i;
    assign accept    = (state_q == ST_REQ) & go & rng4bit_done_i;
    assign hs        = (state_q == ST_HOLD) & word_ready_i;
    assign start_req = go & ((state_q == ST_IDLE) | hs);
    assign to_fire   = (state_q == ST_REQ) & go & ~rng4bit_done_i & (to_cnt_d == TO_MAX);
    assign word_d    = {word_q[WORD_W-5:0], rng4bit_i};
    assign nib_cnt_d = nib_cnt_q + NW'(1);
    assign to_cnt_d  = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);

    puf_rng_rep_check #(.REP_LIMIT(REP_LIMIT)) u_rep_check (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (start_req | rep_fail),
        .valid_i (accept),
        .nib_i   (rng4bit_i),
        .fail_o  (rep_fail)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            nib_cnt_q <= '0;
            to_cnt_q  <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            terr_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q   <= ST_REQ;
                        req_q     <= 1'b1;
                        nib_cnt_q <= '0;
                        to_cnt_q  <= '0;
                    end
                end
                ST_REQ: begin
                    if (!go) begin
                        state_q   <= ST_IDLE;
                        req_q     <= 1'b0;
                        word_q    <= '0;
                        nib_cnt_q <= '0;
                    end else if (rng4bit_done_i) begin
                        to_cnt_q <= '0;
                        if (rep_fail) begin
                            word_q    <= '0;
                            nib_cnt_q <= '0;
                        end else begin
                            word_q <= word_d;
                            if (nib_cnt_d == NIBS_C) begin
                                state_q   <= ST_HOLD;
                                req_q     <= 1'b0;
                                valid_q   <= 1'b1;
                                nib_cnt_q <= '0;
                            end else begin
                                nib_cnt_q <= nib_cnt_d;
                            end
                        end
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_fire) begin
                            state_q   <= ST_IDLE;
                            req_q     <= 1'b0;
                            word_q    <= '0;
                            nib_cnt_q <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_ready_i) begin
                        valid_q <= 1'b0;
                        if (go) begin
                            state_q   <= ST_REQ;
                            req_q     <= 1'b1;
                            nib_cnt_q <= '0;
                            to_cnt_q  <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A new error event outranks a clear in the same cycle.
            if (to_fire)        terr_q <= 1'b1;
            else if (err_clr_i) terr_q <= 1'b0;
            if (rep_fail)       rerr_q <= 1'b1;
            else if (err_clr_i) rerr_q <= 1'b0;
        end
    end

    assign es_rng_req_o  = req_q;
    assign word_o        = word_q;
    assign word_valid_o  = valid_q;
    assign timeout_err_o = terr_q;
    assign rep_err_o     = rerr_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/puf_rng_collector.md
Name: puf_rng_collector

Overview:
Consumer end of the PUF core's 4-bit RNG interface, placed on the entropy-source side.
- Requests nibbles from the PUF core via es_rng_req_o and captures rng4bit_i on each rng4bit_done_i pulse.
- Packs nibbles into WORD_W-bit words, runs a repetition-count health check and a request timeout.
- Delivers finished words downstream over a valid/ready handshake.

Parameters:
WORD_W, 32, output word width; must be a multiple of 4 and at least 8.
TIMEOUT_CYC, 1024, maximum cycles spent in REQ waiting for one nibble before abort.
REP_LIMIT, 8, number of consecutive identical nibbles that flags a health failure; must be at least 2.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous, active-high reset.
enable_i  in  1  collection enable.
rng_mode_i  in  1  PUF core is in RNG mode.
rng4bit_i  in  4  nibble from the PUF core.
rng4bit_done_i  in  1  single-cycle pulse; rng4bit_i is valid in this cycle.
es_rng_req_o  out  1  nibble request to the PUF core.
word_o  out  WORD_W  packed entropy word.
word_valid_o  out  1  word_o is valid.
word_ready_i  in  1  downstream accepts the word.
timeout_err_o  out  1  sticky timeout flag.
rep_err_o  out  1  sticky repetition-health flag.
err_clr_i  in  1  clears both sticky flags.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; every output is 0; all counters, the word register and the previous-nibble register are 0. Reset mid-operation discards any partial or held word.
- States: IDLE, REQ, HOLD.
- IDLE:
  - Moves to REQ when enable_i=1 and rng_mode_i=1.
  - Clears the nibble count, timeout counter and repetition counter on entry to REQ.
- REQ:
  - es_rng_req_o = 1 (registered; high from the first REQ cycle).
  - A done pulse shifts the nibble in: word = {word[WORD_W-5:0], rng4bit_i}. The first nibble ends up in the MSBs.
  - Each done pulse increments the nibble count and resets the timeout counter to 0.
  - On the WORD_W/4-th accepted nibble, go to HOLD. word_valid_o rises the cycle after that done pulse, and es_rng_req_o drops in the same cycle.
  - Health check: if a nibble equals the previous nibble, increment the repetition counter; otherwise set it to 1. The first nibble after entering REQ always sets it to 1.
  - When the repetition counter reaches REP_LIMIT: set rep_err_o, discard the partial word, clear the nibble count, and stay in REQ.
  - Timeout: the counter increments on each REQ cycle without a done pulse. When it reaches TIMEOUT_CYC-1: set timeout_err_o, discard the partial word, go to IDLE.
  - A done pulse in the terminal timeout cycle wins: the nibble is accepted and no timeout is raised.
  - enable_i=0 or rng_mode_i=0: abort to IDLE, discard the partial word. A done pulse in that same cycle is ignored.
- HOLD:
  - word_valid_o = 1 and word_o is stable until word_valid_o & word_ready_i.
  - On the handshake: return to REQ if enable_i & rng_mode_i, otherwise to IDLE. word_valid_o falls the next cycle.
  - Ready asserted in the cycle valid first rises completes the transfer in that cycle.
  - enable_i=0 does not drop a held word.
- rng4bit_done_i outside REQ is ignored.
- Sticky flags:
  - err_clr_i clears both flags the next cycle.
  - A set event in the same cycle as err_clr_i wins.
  - The flags do not stop collection.
- Counter widths:
  - Nibble count: $clog2(WORD_W/4+1).
  - Timeout counter: $clog2(TIMEOUT_CYC); it saturates and never wraps.
  - Repetition counter: $clog2(REP_LIMIT+1).

Decomposition:
- Package puf_rng_pkg holds:
  - the state enum typedef (IDLE/REQ/HOLD);
  - default constants for WORD_W, TIMEOUT_CYC and REP_LIMIT.
- One natural sub-module, puf_rng_rep_check, contains:
  - the previous-nibble register;
  - the repetition counter;
  - the fail pulse output;
  - a clear input driven on REQ entry and after a failure.
- The FSM, packing and timeout stay in the top level.

Test Plan:
- Basic word: enable=1, rng_mode=1, 8 done pulses with nibbles 1..8, ready=1 -> word_o=0x12345678; word_valid_o high the cycle after the 8th pulse for exactly 1 cycle; es_rng_req_o low during HOLD.
- Backpressure: ready=0 for 20 cycles after a word completes -> word_o and word_valid_o stable; no request; extra done pulses ignored; word accepted when ready=1.
- Repetition: nibbles 0x3 repeated 8 times -> rep_err_o=1; partial discarded; next 8 distinct nibbles A,B,C,D,E,F,0,1 -> word 0xABCDEF01.
- Timeout: TIMEOUT_CYC=16, no done pulse -> timeout_err_o=1 and state IDLE after 15 REQ cycles. Repeat with a done pulse in the terminal cycle -> no error.
- Abort: rng_mode_i drops after 3 nibbles -> es_rng_req_o=0 next cycle; on return, the next word contains only new nibbles.
- Flags and reset: err_clr_i coincident with a new timeout -> flag stays 1. rst_i mid-HOLD -> all outputs 0 the next cycle.
